fft_frame_sequencer: RTL and testbench

Frame-level sequencer wrapped around `fft_top`. It accepts a stream of 16-bit real samples over a valid/ready handshake and scatters them into the four RAM banks through the external write ports. It then pulses the FFT start and waits for completion. Finally it unloads the 2048 real results as a valid/ready output stream tagged with bin index, so upstream and downstream logic never touch bank addressing.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_out_skid.sv | 62 ++++++
 rtl/fft_frame_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sequencer state encoding and the bank write-enable helper
// for the FFT frame sequencer.
package fft_pkg;

    localparam int FFT_N       = 2048;
    localparam int FFT_BANKS   = 4;
    localparam int BANK_ADDR_W = 9;
    localparam int IDX_W       = 11;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4
    } seq_state_t;

    // One-hot write enable for the bank that owns a given sample.
    function automatic logic [FFT_BANKS-1:0] bank_onehot(input logic [1:0] bank);
        return FFT_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry valid/ready output buffer; out_valid comes from the registered
// occupancy only, so it never depends on out_ready within a cycle.
module fft_out_skid #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;
    assign pop       = out_valid && out_ready;

    // The producer guarantees no push while full without a pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid) begin
                        slot0 <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        slot0 <= in_data;
                    end else if (in_valid) begin
                        slot1 <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (in_valid) begin
                            slot1 <= in_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around fft_top: scatters a 2048-sample input stream into the
// four banks, starts the transform, then streams the results out with bin index.
//
// Both streams use valid/ready: a transfer happens on every rising clock edge
// where valid and ready are both high; once valid rises, it and the data hold
// until that transfer.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RES_W  = 17,
    parameter int ADDR_W = 9
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iS_VALID,
    input  logic [DATA_W-1:0] iS_DATA,
    output logic              oS_READY,
    output logic              oM_VALID,
    output logic [RES_W-1:0]  oM_DATA,
    output logic [IDX_W-1:0]  oM_INDEX,
    input  logic              iM_READY,
    output logic [DATA_W-1:0] oFFT_DATA,
    output logic [ADDR_W-1:0] oFFT_ADDR_WR,
    output logic [3:0]        oFFT_WE,
    output logic [ADDR_W-1:0] oFFT_ADDR_RD,
    output logic              oFFT_START,
    input  logic              iFFT_RDY,
    input  logic [RES_W-1:0]  iFFT_RE_0,
    input  logic [RES_W-1:0]  iFFT_RE_1,
    input  logic [RES_W-1:0]  iFFT_RE_2,
    input  logic [RES_W-1:0]  iFFT_RE_3,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = ADDR_W + 2;
    localparam int SK_W  = RES_W + CNT_W;

    seq_state_t          state;
    seq_state_t          state_n;

    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W:0]      rd_cnt;
    logic [ADDR_W-1:0]   addr_hold;

    logic                b_vld;
    logic [CNT_W-1:0]    b_idx;
    logic [RES_W-1:0]    rd_data;

    logic                sk_valid;
    logic [SK_W-1:0]     sk_data;
    logic [1:0]          occ;
    logic [2:0]          credit;

    logic                in_hs;
    logic                out_hs;
    logic                last_out;
    logic                rd_issue;

    assign in_hs    = iS_VALID && oS_READY;
    assign out_hs   = sk_valid && iM_READY;
    assign last_out = (state == ST_UNLOAD) && out_hs &&
                      (sk_data[SK_W-1:RES_W] == CNT_W'(FFT_N - 1));

    // Slots committed downstream: buffered entries plus the read returning now,
    // net of the entry leaving this cycle.
    assign credit   = {1'b0, occ} + {2'b00, b_vld} - {2'b00, out_hs};
    assign rd_issue = (state == ST_UNLOAD) && !rd_cnt[CNT_W] && (credit < 3'd2);

    always_comb begin
        state_n = state;
        case (state)
            ST_LOAD: begin
                if (in_hs && (wr_cnt == CNT_W'(FFT_N - 1))) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH:  state_n = ST_START;
            ST_START:  state_n = ST_RUN;
            ST_RUN: begin
                if (iFFT_RDY) begin
                    state_n = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (last_out) begin
                    state_n = ST_LOAD;
                end
            end
            default:   state_n = ST_LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state        <= ST_LOAD;
            oS_READY     <= 1'b0;
            oFFT_START   <= 1'b0;
            oFFT_WE      <= '0;
            oFFT_DATA    <= '0;
            oFFT_ADDR_WR <= '0;
            wr_cnt       <= '0;
        end else begin
            state      <= state_n;
            oS_READY   <= (state_n == ST_LOAD);
            oFFT_START <= (state_n == ST_START);
            oFFT_WE    <= '0;
            if (in_hs) begin
                oFFT_DATA    <= iS_DATA;
                oFFT_ADDR_WR <= wr_cnt[ADDR_W-1:0];
                oFFT_WE      <= bank_onehot(wr_cnt[CNT_W-1:ADDR_W]);
                wr_cnt       <= wr_cnt + 1'b1;
            end
            if (last_out) begin
                wr_cnt <= '0;
            end
        end
    end

    // Read side: the address goes out in the issue cycle, data and its index
    // are paired up one cycle later on the b stage.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_cnt    <= '0;
            addr_hold <= '0;
            b_vld     <= 1'b0;
            b_idx     <= '0;
        end else begin
            b_vld <= rd_issue;
            if (rd_issue) begin
                b_idx     <= rd_cnt[CNT_W-1:0];
                addr_hold <= rd_cnt[ADDR_W-1:0];
                rd_cnt    <= rd_cnt + 1'b1;
            end
            if (last_out) begin
                rd_cnt <= '0;
            end
        end
    end

    always_comb begin
        rd_data = iFFT_RE_0;
        case (b_idx[CNT_W-1:ADDR_W])
            2'd0:    rd_data = iFFT_RE_0;
            2'd1:    rd_data = iFFT_RE_1;
            2'd2:    rd_data = iFFT_RE_2;
            default: rd_data = iFFT_RE_3;
        endcase
    end

    fft_out_skid #(
        .W (SK_W)
    ) u_skid (
        .clk       (iCLK),
        .rst_n     (iRESET),
        .in_valid  (b_vld),
        .in_data   ({b_idx, rd_data}),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .out_ready (iM_READY),
        .count     (occ)
    );

    assign oM_VALID     = sk_valid;
    assign oM_DATA      = sk_data[RES_W-1:0];
    assign oM_INDEX     = sk_data[SK_W-1:RES_W];
    assign oFFT_ADDR_RD = rd_issue ? rd_cnt[ADDR_W-1:0] : addr_hold;
    assign oBUSY        = (state != ST_LOAD);
    assign oFRAME_DONE  = last_out;
    assign dbg_state    = state;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a stub bank-read model
// (bank b returns b*1000 + addr) and a write monitor.
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic        iS_VALID;
    logic [15:0] iS_DATA;
    logic        oS_READY;
    logic        oM_VALID;
    logic [16:0] oM_DATA;
    logic [10:0] oM_INDEX;
    logic        iM_READY;
    logic [15:0] oFFT_DATA;
    logic [8:0]  oFFT_ADDR_WR;
    logic [3:0]  oFFT_WE;
    logic [8:0]  oFFT_ADDR_RD;
    logic        oFFT_START;
    logic        iFFT_RDY;
    logic [16:0] re0, re1, re2, re3;
    logic        oBUSY;
    logic        oFRAME_DONE;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_bad = 0;
    int start_cnt = 0;
    int sready_bad = 0;
    logic [15:0] bank_mem [4][512];

    always #5 iCLK = ~iCLK;

    fft_frame_sequencer dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iS_VALID(iS_VALID), .iS_DATA(iS_DATA), .oS_READY(oS_READY),
        .oM_VALID(oM_VALID), .oM_DATA(oM_DATA), .oM_INDEX(oM_INDEX), .iM_READY(iM_READY),
        .oFFT_DATA(oFFT_DATA), .oFFT_ADDR_WR(oFFT_ADDR_WR), .oFFT_WE(oFFT_WE),
        .oFFT_ADDR_RD(oFFT_ADDR_RD), .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY),
        .iFFT_RE_0(re0), .iFFT_RE_1(re1), .iFFT_RE_2(re2), .iFFT_RE_3(re3),
        .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .dbg_state(dbg_state)
    );

    // Synchronous-read bank stub
    always @(posedge iCLK) begin
        re0 <= 17'(oFFT_ADDR_RD);
        re1 <= 17'd1000 + 17'(oFFT_ADDR_RD);
        re2 <= 17'd2000 + 17'(oFFT_ADDR_RD);
        re3 <= 17'd3000 + 17'(oFFT_ADDR_RD);
    end

    always @(negedge iCLK) begin
        if (|oFFT_WE) begin
            we_cnt++;
            if (!$onehot(oFFT_WE)) we_bad++;
            for (int b = 0; b < 4; b++) begin
                if (oFFT_WE[b]) bank_mem[b][oFFT_ADDR_WR] = oFFT_DATA;
            end
        end
        if (oFFT_START) start_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame();
        int guard;
        for (int k = 0; k < 2048; k++) begin
            @(negedge iCLK);
            guard = 0;
            while (!oS_READY && guard < 50) begin
                @(negedge iCLK);
                guard++;
            end
            iS_VALID = 1'b1;
            iS_DATA  = 16'(k);
            @(posedge iCLK);
        end
    endtask

    task automatic unload(input int duty, input int stop_at, output int n_cyc, output int n_got);
        int          exp_idx;
        int          guard;
        logic        held;
        logic [16:0] hd;
        logic [10:0] hi;
        exp_idx = 0; guard = 0; held = 1'b0; n_cyc = 0; hd = '0; hi = '0;
        while (exp_idx < 2048 && guard < 20000) begin
            @(negedge iCLK);
            guard++;
            if (oS_READY) sready_bad++;
            if (held) begin
                chk("stall_valid", 32'(oM_VALID), 32'd1);
                chk("stall_data", 32'(oM_DATA), 32'(hd));
                chk("stall_index", 32'(oM_INDEX), 32'(hi));
                held = 1'b0;
            end
            if (oM_VALID && stop_at >= 0 && exp_idx == stop_at) break;
            iM_READY = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            #1;
            if (oM_VALID || exp_idx > 0) n_cyc++;
            if (oM_VALID && iM_READY) begin
                chk("out_index", 32'(oM_INDEX), 32'(exp_idx));
                chk("out_data", 32'(oM_DATA), 32'((exp_idx / 512) * 1000 + (exp_idx % 512)));
                chk("frame_done", 32'(oFRAME_DONE), 32'(exp_idx == 2047));
                exp_idx++;
            end else if (oM_VALID) begin
                held = 1'b1;
                hd   = oM_DATA;
                hi   = oM_INDEX;
            end
        end
        n_got = exp_idx;
    endtask

    int n_cyc, n_got, we0, st0;

    initial begin
        iRESET = 1'b1; iS_VALID = 1'b0; iS_DATA = '0; iM_READY = 1'b0; iFFT_RDY = 1'b0;
        #2 iRESET = 1'b0;
        @(negedge iCLK); @(negedge iCLK);
        chk("rst_s_ready", 32'(oS_READY), 32'd0);
        chk("rst_we", 32'(oFFT_WE), 32'd0);
        chk("rst_start", 32'(oFFT_START), 32'd0);
        chk("rst_m_valid", 32'(oM_VALID), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_addr_rd", 32'(oFFT_ADDR_RD), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_LOAD));
        iRESET = 1'b1;
        @(negedge iCLK);
        chk("post_rst_s_ready", 32'(oS_READY), 32'd1);

        // RDY pulse while loading must be ignored
        iFFT_RDY = 1'b1;
        @(negedge iCLK);
        iFFT_RDY = 1'b0;
        chk("spurious_rdy_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("spurious_rdy_busy", 32'(oBUSY), 32'd0);

        // Frame 1: scatter, start sequencing, full-rate unload
        we0 = we_cnt; st0 = start_cnt;
        iM_READY = 1'b1;
        load_frame();
        @(negedge iCLK);
        iS_VALID = 1'b0;
        chk("flush_s_ready", 32'(oS_READY), 32'd0);
        chk("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
        chk("flush_we", 32'(oFFT_WE), 32'b1000);
        chk("flush_addr", 32'(oFFT_ADDR_WR), 32'd511);
        chk("flush_data", 32'(oFFT_DATA), 32'd2047);
        chk("flush_start", 32'(oFFT_START), 32'd0);
        @(negedge iCLK);
        chk("start_pulse", 32'(oFFT_START), 32'd1);
        chk("start_we", 32'(oFFT_WE), 32'd0);
        @(negedge iCLK);
        chk("run_start_low", 32'(oFFT_START), 32'd0);
        chk("run_state", 32'(dbg_state), 32'(ST_RUN));
        repeat (96) @(negedge iCLK);
        chk("we_pulses", 32'(we_cnt - we0), 32'd2048);
        chk("we_onehot", 32'(we_bad), 32'd0);
        chk("start_count", 32'(start_cnt - st0), 32'd1);
        chk("mem_b0_a0", 32'(bank_mem[0][0]), 32'd0);
        chk("mem_b1_a0", 32'(bank_mem[1][0]), 32'd512);
        chk("mem_b3_a511", 32'(bank_mem[3][511]), 32'd2047);
        chk("run_wait_state", 32'(dbg_state), 32'(ST_RUN));
        iFFT_RDY = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iFFT_RDY = 1'b0;
        chk("first_rd_addr", 32'(oFFT_ADDR_RD), 32'd0);
        chk("r1_m_valid", 32'(oM_VALID), 32'd0);
        chk("unload_state", 32'(dbg_state), 32'(ST_UNLOAD));
        @(negedge iCLK);
        chk("r2_m_valid", 32'(oM_VALID), 32'd0);
        @(posedge iCLK);
        #1;
        chk("r3_m_valid", 32'(oM_VALID), 32'd1);
        chk("r3_index", 32'(oM_INDEX), 32'd0);
        chk("r3_data", 32'(oM_DATA), 32'd0);
        sready_bad = 0;
        unload(100, -1, n_cyc, n_got);
        chk("f1_count", 32'(n_got), 32'd2048);
        chk("f1_cycles", 32'(n_cyc), 32'd2048);
        chk("f1_s_ready_low", 32'(sready_bad), 32'd0);
        @(negedge iCLK);
        chk("f1_back_to_load", 32'(oS_READY), 32'd1);
        chk("f1_busy_low", 32'(oBUSY), 32'd0);

        // Frame 2: 30% downstream duty
        load_frame();
        @(negedge iCLK);
        iS_VALID = 1'b0;
        iM_READY = 1'b0;
        repeat (4) @(negedge iCLK);
        iFFT_RDY = 1'b1;
        @(negedge iCLK);
        iFFT_RDY = 1'b0;
        sready_bad = 0;
        unload(30, -1, n_cyc, n_got);
        chk("f2_count", 32'(n_got), 32'd2048);
        chk("f2_s_ready_low", 32'(sready_bad), 32'd0);

        // Frame 3: reset while index 700 is at the output
        load_frame();
        @(negedge iCLK);
        iS_VALID = 1'b0;
        repeat (4) @(negedge iCLK);
        iFFT_RDY = 1'b1;
        @(negedge iCLK);
        iFFT_RDY = 1'b0;
        unload(100, 700, n_cyc, n_got);
        chk("f3_stop_index", 32'(oM_INDEX), 32'd700);
        iRESET = 1'b0;
        iM_READY = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(oM_VALID), 32'd0);
        chk("mid_rst_m_data", 32'(oM_DATA), 32'd0);
        chk("mid_rst_m_index", 32'(oM_INDEX), 32'd0);
        chk("mid_rst_addr_rd", 32'(oFFT_ADDR_RD), 32'd0);
        chk("mid_rst_we", 32'(oFFT_WE), 32'd0);
        chk("mid_rst_start", 32'(oFFT_START), 32'd0);
        chk("mid_rst_busy", 32'(oBUSY), 32'd0);
        chk("mid_rst_s_ready", 32'(oS_READY), 32'd0);
        chk("mid_rst_done", 32'(oFRAME_DONE), 32'd0);
        repeat (3) @(negedge iCLK);
        iRESET = 1'b1;
        @(negedge iCLK);
        chk("rerst_s_ready", 32'(oS_READY), 32'd1);
        iS_VALID = 1'b1;
        iS_DATA  = 16'h1234;
        @(posedge iCLK);
        @(negedge iCLK);
        iS_VALID = 1'b0;
        chk("next_frame_we", 32'(oFFT_WE), 32'b0001);
        chk("next_frame_addr", 32'(oFFT_ADDR_WR), 32'd0);
        chk("next_frame_data", 32'(oFFT_DATA), 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
